// File: rtl/ddram_arb_pkg.sv
// Shared types and helpers for the two-port DDRAM byte arbiter.
// The cache feature is enabled with the DDRAM_ARB_CACHE_EN macro.
package ddram_arb_pkg;

  typedef enum logic [1:0] {IDLE, CMD, RWAIT, ACK} state_t;

  localparam int DDRAM_WORD_W = 29;

  // One-hot byte-lane mask for a byte offset inside a 64-bit word
  function automatic logic [7:0] be_of(input logic [2:0] lane);
    return 8'b1 << lane;
  endfunction

  // Pick one byte lane out of a 64-bit word
  function automatic logic [7:0] byte_of(input logic [63:0] word, input logic [2:0] lane);
    return word[8*lane +: 8];
  endfunction

endpackage

// File: rtl/ddram_arb_if.sv
// DDRAM Avalon-style bus: the arbiter is the master, the memory side the slave.
interface ddram_arb_if;
  import ddram_arb_pkg::*;

  logic                    busy;
  logic [63:0]             dout;
  logic                    dout_ready;
  logic [DDRAM_WORD_W-1:0] addr;
  logic [7:0]              burstcnt;
  logic [63:0]             din;
  logic [7:0]              be;
  logic                    rd;
  logic                    we;

  modport master (
    input  busy, dout, dout_ready,
    output addr, burstcnt, din, be, rd, we
  );

  modport slave (
    output busy, dout, dout_ready,
    input  addr, burstcnt, din, be, rd, we
  );

endinterface

// File: rtl/ddram_arb_cache.sv
// Single-word read cache for one requester port (used with DDRAM_ARB_CACHE_EN).
// Holds one 64-bit word; filled on read misses, byte-patched by any write
// whose word address matches the tag (write-through, no write allocate).
module ddram_arb_cache
  import ddram_arb_pkg::*;
(
  input  logic                    clk_sys,
  input  logic                    rst_n,
  input  logic [DDRAM_WORD_W-1:0] look_word,
  input  logic [2:0]              look_lane,
  output logic                    hit,
  output logic [7:0]              hit_byte,
  input  logic                    fill_en,
  input  logic [DDRAM_WORD_W-1:0] fill_word,
  input  logic [63:0]             fill_data,
  input  logic                    upd_en,
  input  logic [DDRAM_WORD_W-1:0] upd_word,
  input  logic [2:0]              upd_lane,
  input  logic [7:0]              upd_byte
);

  logic                    valid;
  logic [DDRAM_WORD_W-1:0] tag;
  logic [63:0]             data;

  assign hit      = valid && (tag == look_word);
  assign hit_byte = byte_of(data, look_lane);

  // Tag and valid bit: cleared by reset, set on a miss fill
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
    end else if (fill_en) begin
      valid <= 1'b1;
      tag   <= fill_word;
    end
  end

  // Cached word: whole-word fill, or single byte patch on a matching write
  always_ff @(posedge clk_sys) begin
    if (fill_en) begin
      data <= fill_data;
    end else if (upd_en && valid && (tag == upd_word)) begin
      data[8*upd_lane +: 8] <= upd_byte;
    end
  end

endmodule

// File: rtl/ddram_arb.sv
// Two-port round-robin arbiter turning byte reads/writes into lane-masked
// single-beat 64-bit DDRAM accesses. Optional per-port one-word read cache
// is built when DDRAM_ARB_CACHE_EN is defined.
module ddram_arb
  import ddram_arb_pkg::*;
#(
  parameter int                      AW    = 21,
  parameter logic [DDRAM_WORD_W-1:0] BASE0 = 29'h0300000,
  parameter logic [DDRAM_WORD_W-1:0] BASE1 = 29'h0340000
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic [AW-1:0] p0_addr,
  input  logic [7:0]    p0_din,
  input  logic          p0_rd,
  input  logic          p0_wr,
  output logic [7:0]    p0_dout,
  output logic          p0_ack,
  input  logic [AW-1:0] p1_addr,
  input  logic [7:0]    p1_din,
  input  logic          p1_rd,
  input  logic          p1_wr,
  output logic [7:0]    p1_dout,
  output logic          p1_ack,
  ddram_arb_if.master   ddr
);

  state_t                  state, state_nx;
  logic                    req0, req1, pick1, grant_en;
  logic                    sel_wr, sel_hit, hit_rd;
  logic [AW-1:0]           sel_addr;
  logic [7:0]              sel_din;
  logic [DDRAM_WORD_W-1:0] word0, word1, sel_word;
  logic                    hit0, hit1;

  // Registered transaction, captured at grant and held until the next grant
  logic                    gnt, last_grant, op_wr;
  logic [2:0]              lane_r;
  logic [DDRAM_WORD_W-1:0] addr_r;
  logic [7:0]              be_r;
  logic [63:0]             din_r;
  logic [7:0]              dout0, dout1;
  logic                    cmd_rd, cmd_we, ack0, ack1;

  assign req0  = p0_rd | p0_wr;
  assign req1  = p1_rd | p1_wr;
  // Port 1 wins if alone, or on a tie when port 0 was served last
  assign pick1    = req1 & (~req0 | ~last_grant);
  assign grant_en = (state == IDLE) & (req0 | req1);

  assign word0 = BASE0 + DDRAM_WORD_W'(p0_addr[AW-1:3]);
  assign word1 = BASE1 + DDRAM_WORD_W'(p1_addr[AW-1:3]);

  assign sel_addr = pick1 ? p1_addr : p0_addr;
  assign sel_din  = pick1 ? p1_din  : p0_din;
  assign sel_wr   = pick1 ? p1_wr   : p0_wr;
  assign sel_word = pick1 ? word1   : word0;
  assign sel_hit  = pick1 ? hit1    : hit0;
  // Write beats read when a requester raises both
  assign hit_rd   = ~sel_wr & sel_hit;

`ifdef DDRAM_ARB_CACHE_EN
  logic [7:0] hit_byte0, hit_byte1;
  logic       fill0, fill1, upd_en;

  assign upd_en = grant_en & sel_wr;
  assign fill0  = (state == RWAIT) & ddr.dout_ready & ~gnt;
  assign fill1  = (state == RWAIT) & ddr.dout_ready &  gnt;

  ddram_arb_cache u_cache0 (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .look_word (word0),
    .look_lane (p0_addr[2:0]),
    .hit       (hit0),
    .hit_byte  (hit_byte0),
    .fill_en   (fill0),
    .fill_word (addr_r),
    .fill_data (ddr.dout),
    .upd_en    (upd_en),
    .upd_word  (sel_word),
    .upd_lane  (sel_addr[2:0]),
    .upd_byte  (sel_din)
  );

  ddram_arb_cache u_cache1 (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .look_word (word1),
    .look_lane (p1_addr[2:0]),
    .hit       (hit1),
    .hit_byte  (hit_byte1),
    .fill_en   (fill1),
    .fill_word (addr_r),
    .fill_data (ddr.dout),
    .upd_en    (upd_en),
    .upd_word  (sel_word),
    .upd_lane  (sel_addr[2:0]),
    .upd_byte  (sel_din)
  );
`else
  assign hit0 = 1'b0;
  assign hit1 = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and command/ack decode
  always_comb begin
    state_nx = state;
    cmd_rd   = 1'b0;
    cmd_we   = 1'b0;
    ack0     = 1'b0;
    ack1     = 1'b0;
    case (state)
      IDLE:    if (grant_en) state_nx = hit_rd ? ACK : CMD;
      CMD: begin
        cmd_rd = ~op_wr;
        cmd_we =  op_wr;
        if (!ddr.busy) state_nx = op_wr ? ACK : RWAIT;
      end
      // A dout_ready seen outside RWAIT is stale and deliberately ignored
      RWAIT:   if (ddr.dout_ready) state_nx = ACK;
      ACK: begin
        ack0     = ~gnt;
        ack1     =  gnt;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Latch the winning request and the round-robin pointer at grant
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      op_wr      <= 1'b0;
      lane_r     <= '0;
      addr_r     <= '0;
      be_r       <= '0;
      din_r      <= '0;
    end else if (grant_en) begin
      gnt        <= pick1;
      last_grant <= pick1;
      op_wr      <= sel_wr;
      lane_r     <= sel_addr[2:0];
      addr_r     <= sel_word;
      be_r       <= be_of(sel_addr[2:0]);
      din_r      <= {8{sel_din}};
    end
  end

  // Per-port read data: from DDRAM on dout_ready, or from the cache on a hit
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      dout0 <= '0;
      dout1 <= '0;
    end else if ((state == RWAIT) && ddr.dout_ready) begin
      if (gnt) dout1 <= byte_of(ddr.dout, lane_r);
      else     dout0 <= byte_of(ddr.dout, lane_r);
    end
`ifdef DDRAM_ARB_CACHE_EN
    else if (grant_en && hit_rd) begin
      if (pick1) dout1 <= hit_byte1;
      else       dout0 <= hit_byte0;
    end
`endif
  end

  assign ddr.addr     = addr_r;
  assign ddr.be       = be_r;
  assign ddr.din      = din_r;
  assign ddr.rd       = cmd_rd;
  assign ddr.we       = cmd_we;
  assign ddr.burstcnt = 8'd1;

  assign p0_dout = dout0;
  assign p1_dout = dout1;
  assign p0_ack  = ack0;
  assign p1_ack  = ack1;

endmodule

// File: tb/tb_ddram_arb.sv
// Directed bench for ddram_arb with a scoreboard of expected acks/read data.
// Cache scenarios run when DDRAM_ARB_CACHE_EN is defined.
module tb_ddram_arb;

  localparam logic [28:0] TB_BASE0 = 29'h0300000;
`ifdef DDRAM_ARB_CACHE_EN
  // Both ports share one window so a port-1 write can land in port-0's cached word
  localparam logic [28:0] TB_BASE1 = TB_BASE0;
`else
  localparam logic [28:0] TB_BASE1 = 29'h0340000;
`endif

  logic        clk_sys;
  logic        rst_n;
  logic [20:0] p0_addr, p1_addr;
  logic [7:0]  p0_din, p1_din, p0_dout, p1_dout;
  logic        p0_rd, p0_wr, p0_ack, p1_rd, p1_wr, p1_ack;

  ddram_arb_if ddr ();

  ddram_arb #(.AW(21), .BASE0(TB_BASE0), .BASE1(TB_BASE1)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .p0_addr (p0_addr),
    .p0_din  (p0_din),
    .p0_rd   (p0_rd),
    .p0_wr   (p0_wr),
    .p0_dout (p0_dout),
    .p0_ack  (p0_ack),
    .p1_addr (p1_addr),
    .p1_din  (p1_din),
    .p1_rd   (p1_rd),
    .p1_wr   (p1_wr),
    .p1_dout (p1_dout),
    .p1_ack  (p1_ack),
    .ddr     (ddr)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic       port;
    logic       is_rd;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [63:0] mem_word(input logic [28:0] w);
    return 64'h0F1E_2D3C_4B5A_6978 ^ {w, 35'h0} ^ {35'h0, w};
  endfunction

  function automatic logic [7:0] lane_byte(input logic [63:0] w, input int lane);
    logic [63:0] s;
    s = w >> (8 * lane);
    return s[7:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_sys);
  endtask

  task automatic sb_check(input string tag);
    exp_t       e;
    logic       port;
    logic [7:0] d;
    chk({tag, "_sb_nonempty"}, sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e    = sb.pop_front();
      port = p1_ack;
      chk({tag, "_port"}, port, e.port);
      if (e.is_rd) begin
        d = port ? p1_dout : p0_dout;
        chk({tag, "_data"}, d, e.data);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rd"},   ddr.rd, 0);
    chk({tag, "_we"},   ddr.we, 0);
    chk({tag, "_addr"}, ddr.addr, 0);
    chk({tag, "_be"},   ddr.be, 0);
    chk({tag, "_din"},  ddr.din, 0);
    chk({tag, "_ack0"}, p0_ack, 0);
    chk({tag, "_ack1"}, p1_ack, 0);
  endtask

  // Memory responder: answers reads from mem_word, counts commands, stops at the first ack
  task automatic serve_one(input string tag, output int rd_cyc, output int we_cyc, output int lat);
    bit          pend;
    bit          got;
    logic [28:0] pa;
    pend = 0; got = 0; pa = '0;
    rd_cyc = 0; we_cyc = 0; lat = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      step();
      ddr.dout_ready = 1'b0;
      if (pend) begin
        ddr.dout_ready = 1'b1;
        ddr.dout       = mem_word(pa);
        pend           = 0;
      end
      if (ddr.rd) begin
        rd_cyc++;
        if (!ddr.busy) begin
          pend = 1;
          pa   = ddr.addr;
        end
      end
      if (ddr.we) we_cyc++;
      if (p0_ack | p1_ack) begin
        got = 1;
        lat = c + 1;
        sb_check(tag);
        p0_rd = 0; p0_wr = 0; p1_rd = 0; p1_wr = 0;
      end
    end
    chk({tag, "_ack_seen"}, got, 1);
    step();
    ddr.dout_ready = 1'b0;
    chk({tag, "_ack_pulse0"}, p0_ack, 0);
    chk({tag, "_ack_pulse1"}, p1_ack, 0);
  endtask

  initial begin
    int          rdc, wec, lat, nack, acks0, acks1;
    bit          pend;
    logic [28:0] pa;
    logic [7:0]  e0, e1;

    rst_n = 1'b0;
    p0_addr = '0; p0_din = '0; p0_rd = 0; p0_wr = 0;
    p1_addr = '0; p1_din = '0; p1_rd = 0; p1_wr = 0;
    ddr.busy = 1'b0; ddr.dout = '0; ddr.dout_ready = 1'b0;

    // Reset values
    repeat (2) step();
    check_idle_outputs("rst");
    chk("rst_burstcnt", ddr.burstcnt, 8'd1);
    chk("rst_dout0", p0_dout, 0);
    chk("rst_dout1", p1_dout, 0);
    rst_n = 1'b1;
    step();

    // Port 0 byte write, busy low
    p0_addr = 21'h00003; p0_din = 8'hA5; p0_wr = 1;
    step();
    chk("t1_we", ddr.we, 1);
    chk("t1_rd", ddr.rd, 0);
    chk("t1_addr", ddr.addr, TB_BASE0);
    chk("t1_be", ddr.be, 8'h08);
    chk("t1_din", ddr.din, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("t1_ack_early", p0_ack, 0);
    step();
    chk("t1_ack", p0_ack, 1);
    chk("t1_we_one_cycle", ddr.we, 0);
    p0_wr = 0;
    step();
    chk("t1_ack_pulse", p0_ack, 0);
    chk("t1_we_off", ddr.we, 0);

    // Port 1 read with busy back-pressure and delayed dout_ready
    p1_addr = 21'h00015; p1_rd = 1; ddr.busy = 1;
    sb.push_back('{1'b1, 1'b1, 8'h22});
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_rd_held", ddr.rd, 1);
      chk("t2_addr", ddr.addr, TB_BASE1 + 29'd2);
      chk("t2_be", ddr.be, 8'h20);
      if (i == 3) ddr.busy = 0;
    end
    for (int j = 0; j < 4; j++) begin
      step();
      chk("t2_rd_released", ddr.rd, 0);
      chk("t2_no_ack", p1_ack, 0);
    end
    step();
    ddr.dout_ready = 1; ddr.dout = 64'h0011_2233_4455_6677;
    step();
    ddr.dout_ready = 0;
    chk("t2_ack", p1_ack, 1);
    sb_check("t2");
    p1_rd = 0;
    step();
    chk("t2_ack_pulse", p1_ack, 0);
    chk("t2_dout_held", p1_dout, 8'h22);

    // Both ports reading continuously from reset: strict alternation
    rst_n = 0; step(); rst_n = 1; step();
    p0_addr = 21'h0000A; p1_addr = 21'h00107;
    e0 = lane_byte(mem_word(TB_BASE0 + 29'd1), 2);
    e1 = lane_byte(mem_word(TB_BASE1 + 29'h20), 7);
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{1'b0, 1'b1, e0});
      sb.push_back('{1'b1, 1'b1, e1});
    end
    p0_rd = 1; p1_rd = 1;
    pend = 0; pa = '0; nack = 0; acks0 = 0; acks1 = 0;
    for (int c = 0; c < 200 && nack < 8; c++) begin
      step();
      ddr.dout_ready = 0;
      if (pend) begin
        ddr.dout_ready = 1; ddr.dout = mem_word(pa); pend = 0;
      end
      if (ddr.rd && !ddr.busy) begin
        pend = 1; pa = ddr.addr;
      end
      if (p0_ack | p1_ack) begin
        chk("t3_single_ack", p0_ack & p1_ack, 0);
        sb_check("t3");
        nack++;
        if (p1_ack) acks1++;
        else        acks0++;
      end
    end
    p0_rd = 0; p1_rd = 0;
    step();
    ddr.dout_ready = 0;
    step();
    chk("t3_total_acks", nack, 8);
    chk("t3_acks_p0", acks0, 4);
    chk("t3_acks_p1", acks1, 4);
    chk("t3_sb_drained", sb.size(), 0);

    // Reset while waiting for read data; late dout_ready must be ignored
    p0_addr = 21'h00021; p0_rd = 1;
    step();
    chk("t4_rd", ddr.rd, 1);
    step();
    chk("t4_in_rwait", ddr.rd, 0);
    rst_n = 0;
    #1;
    check_idle_outputs("t4_rst");
    p0_rd = 0;
    step();
    check_idle_outputs("t4_rst_hold");
    rst_n = 1;
    step(); step();
    ddr.dout_ready = 1; ddr.dout = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int j = 0; j < 4; j++) begin
      step();
      ddr.dout_ready = 0;
      chk("t4_no_ack0", p0_ack, 0);
      chk("t4_no_ack1", p1_ack, 0);
      chk("t4_no_rd", ddr.rd, 0);
    end
    chk("t4_dout_cleared", p0_dout, 0);
    p0_addr = 21'h00021; p0_rd = 1;
    sb.push_back('{1'b0, 1'b1, lane_byte(mem_word(TB_BASE0 + 29'd4), 1)});
    serve_one("t4_new", rdc, wec, lat);
    chk("t4_new_rd_issued", rdc, 1);

    // rd and wr together: only a write goes out
    p0_addr = 21'h00002; p0_din = 8'h3C; p0_rd = 1; p0_wr = 1;
    sb.push_back('{1'b0, 1'b0, 8'h00});
    serve_one("t5", rdc, wec, lat);
    chk("t5_no_rd", rdc, 0);
    chk("t5_one_we", wec, 1);
    chk("t5_latency", lat, 2);

`ifdef DDRAM_ARB_CACHE_EN
    // Miss then hit on the same word
    p0_addr = 21'h00008; p0_rd = 1;
    sb.push_back('{1'b0, 1'b1, lane_byte(mem_word(TB_BASE0 + 29'd1), 0)});
    serve_one("c1_miss", rdc, wec, lat);
    chk("c1_miss_rd", rdc, 1);
    p0_addr = 21'h00009; p0_rd = 1;
    sb.push_back('{1'b0, 1'b1, lane_byte(mem_word(TB_BASE0 + 29'd1), 1)});
    serve_one("c2_hit", rdc, wec, lat);
    chk("c2_hit_no_rd", rdc, 0);
    chk("c2_hit_latency", lat, 1);
    // Port 1 writes into the cached word; port 0 then reads the new byte from cache
    p1_addr = 21'h00009; p1_din = 8'h5C; p1_wr = 1;
    sb.push_back('{1'b1, 1'b0, 8'h00});
    serve_one("c3_wr", rdc, wec, lat);
    chk("c3_we", wec, 1);
    p0_addr = 21'h00009; p0_rd = 1;
    sb.push_back('{1'b0, 1'b1, 8'h5C});
    serve_one("c4_hit", rdc, wec, lat);
    chk("c4_hit_no_rd", rdc, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddram_arb.md
Name: ddram_arb

Overview:
- Two-port round-robin arbiter for the HPS DDR3 interface: the DDRAM_* Avalon-style port, 64-bit words, single-beat bursts.
- Each port is a byte-wide requester, e.g. General Sound memory and the ROM/tape loader buffer.
- Converts byte reads and writes into lane-masked 64-bit accesses at a per-port word base.
- Sequences the BUSY / DOUT_READY handshake and returns a one-cycle ack per request.

Parameters:
- AW, 21, byte-address width per port.
- BASE0, 29'h0300000, DDRAM word-address base for port 0.
- BASE1, 29'h0340000, DDRAM word-address base for port 1.

Ports:
- clk_sys  in  1  system clock; DDRAM_CLK is driven from it externally.
- rst_n  in  1  reset, asynchronous, active-low.
- p0_addr  in  AW  port 0 byte address.
- p0_din  in  8  port 0 write data.
- p0_rd  in  1  port 0 read request; level, held until ack.
- p0_wr  in  1  port 0 write request; level, held until ack.
- p0_dout  out  8  port 0 read data, valid in the p0_ack cycle and held afterwards.
- p0_ack  out  1  port 0 completion, 1-cycle pulse.
- p1_*  (same six signals as p0_*)  port 1.
- ddram_busy  in  1  DDRAM_BUSY.
- ddram_dout  in  64  DDRAM_DOUT.
- ddram_dout_ready  in  1  DDRAM_DOUT_READY.
- ddram_addr  out  29  DDRAM_ADDR.
- ddram_burstcnt  out  8  constant 8'd1.
- ddram_din  out  64  DDRAM_DIN.
- ddram_be  out  8  DDRAM_BE.
- ddram_rd  out  1  DDRAM_RD.
- ddram_we  out  1  DDRAM_WE.

Behaviour:
- Reset values: all outputs 0 except ddram_burstcnt=1; state IDLE; last_grant=1, so port 0 wins the first tie.
- Word address: ddram_addr = BASEn + addr[AW-1:3]. Unsigned add, truncated to 29 bits.
- Lane select: ddram_be = 8'b1 << addr[2:0].
- Write data: ddram_din = {8{din}}.
- A request is rd|wr. If a requester asserts both, wr takes precedence.
- IDLE:
  - If exactly one port requests, grant it.
  - If both request, grant the port != last_grant.
  - On grant: register addr/din/op and grant id, update last_grant, go to CMD.
  - ddram_dout_ready seen in IDLE (stale, e.g. after reset mid-read) is ignored.
- CMD:
  - Drive ddram_rd or ddram_we together with addr/be/din.
  - Hold all of them unchanged while ddram_busy=1.
  - The command is accepted on a clk_sys edge with ddram_busy=0.
  - After acceptance: a write goes to ACK; a read goes to RWAIT.
- RWAIT:
  - rd/we deasserted.
  - On ddram_dout_ready, capture ddram_dout[8*lane +: 8] into the granted port's dout, then go to ACK.
- ACK:
  - Pulse pN_ack for one cycle, then return to IDLE.
  - The requester must drop rd/wr in the cycle after ack; a request still high in IDLE is treated as a new request.
- Latency with busy=0:
  - Write: request seen at edge 0, WE accepted at edge 1, ack high during cycle 2.
  - Read: ack is high in the cycle after the dout_ready edge.
- Only one transaction is outstanding at a time; requests from the other port are queued by level and never dropped.
- Starvation bound: a continuously requesting port is granted within one transaction of the other port.
- Address change while a request is pending and unacked is illegal; the arbiter uses the value registered at grant.
- Async reset mid-CMD or mid-RWAIT: outputs clear immediately, no ack is issued, and the pending read response is discarded per the IDLE rule.

Optional Feature:
- Macro: DDRAM_ARB_CACHE_EN.
- With the macro defined:
  - Each port keeps one cached 64-bit word: tag, data, valid.
  - A read hit bypasses DDRAM: ack in the cycle after grant, no ddram_rd. Hits still consume a grant slot.
  - A read miss fills the cache from ddram_dout.
  - Writes are write-through. Any write, from either port, to a word matching a cache tag updates that byte in the cache; tags compare full 29-bit word addresses.
  - Reset clears the valid bits.
- Without the macro: every read goes to DDRAM, and no cache registers exist.

Decomposition:
- Package ddram_arb_pkg holds:
  - state enum {IDLE, CMD, RWAIT, ACK};
  - DDRAM_WORD_W=29;
  - lane-mask function be_of(addr[2:0]);
  - byte-extract function.
- Sub-module ddram_arb_cache: one per port, instantiated only under DDRAM_ARB_CACHE_EN. Handles tag compare, fill and byte update.

Test Plan:
- Port 0 write of 8'hA5 at addr 21'h00003 with busy=0:
  - ddram_we for exactly 1 cycle, addr=BASE0, be=8'h08, din=64'hA5A5_A5A5_A5A5_A5A5;
  - p0_ack 2 cycles after the request.
- Port 1 read at addr 21'h00015, busy held 3 cycles, dout_ready 5 cycles after acceptance with ddram_dout=64'h0011_2233_4455_6677:
  - ddram_rd held 4 cycles with stable addr=BASE1+2;
  - p1_dout=8'h22;
  - p1_ack one cycle after dout_ready.
- p0 and p1 both read continuously from reset: grants alternate 0,1,0,1; 8 acks total, 4 per port, none lost.
- Reset asserted while in RWAIT, dout_ready arriving 2 cycles after release:
  - no ack issued;
  - outputs 0 during reset;
  - next p0 read completes with its own data.
- Simultaneous p0_rd and p0_wr: only a write is issued.
- DDRAM_ARB_CACHE_EN defined, reads at p0 addr 8 then 9:
  - second read acks with no ddram_rd.
  - Then a p1 write to the same word; the next p0 read of that byte returns the new value with no ddram_rd.
